regfile_wb_scheduler: RTL and testbench

- Shares the register file's single write port between two writeback sources: the ALU result path and the memory-load return path.
- Tracks in-flight destination registers in a 32-entry busy scoreboard.
- Flags read-after-write and write-after-write hazards for the issue stage.
- Sits between execute/memory stages and the regfile; its outputs drive the regfile's write_enable, write_add and z5_output directly.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 60 ++++++
 rtl/regfile_wb_scheduler.sv | 122 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the regfile writeback scheduler.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  typedef logic [RF_ADDR_W-1:0] rf_index_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for in-flight destination registers.
// It also gates issue and reports source-operand hazards.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_add,
  output logic                   issue_ready,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_add,
  input  logic [ADDR_W-1:0]      r1_add,
  input  logic [ADDR_W-1:0]      r2_add,
  output logic                   hazard,
  output logic [(1<<ADDR_W)-1:0] busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  assign issue_ready = !r_busy[issue_add];
  assign busy        = r_busy;

  // The write port lags the grant by a cycle, so a commit in progress is
  // still a hazard: the regfile's registered read returns the old value.
  assign hazard = r_busy[r1_add] | r_busy[r2_add] |
                  (clr_en & ((clr_add == r1_add) | (clr_add == r2_add)));

  // One-hot set and clear masks for this cycle.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && issue_ready) begin
      w_set[issue_add] = 1'b1;
    end else begin
      w_set = '0;
    end
    if (clr_en) begin
      w_clr[clr_add] = 1'b1;
    end else begin
      w_clr = '0;
    end
  end

  // Busy vector update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy | w_set) & ~w_clr;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the ALU and load writeback paths onto the single regfile write port.
// Define RF_MEM_PRIORITY_EN for fixed load priority; the default is round-robin.
module regfile_wb_scheduler
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int RF_ADD_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_add,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_add,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_add,
  output logic                   issue_ready,
  input  logic [ADDR_W-1:0]      r1_add,
  input  logic [ADDR_W-1:0]      r2_add,
  output logic                   hazard,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   write_enable,
  output logic [RF_ADD_W-1:0]    write_add,
  output logic [DATA_W-1:0]      z5_output
);

  logic              w_alu_grant;
  logic              w_mem_grant;
  logic [ADDR_W-1:0] w_win_add;
  logic [DATA_W-1:0] w_win_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_wadd;
  logic [DATA_W-1:0] r_wdata;

`ifdef RF_MEM_PRIORITY_EN
  // Loads always win a tie.
  always_comb begin
    w_mem_grant = mem_valid;
    w_alu_grant = alu_valid && !mem_valid;
  end
`else
  wb_src_e r_last_grant;

  // Round-robin: on a tie the source that did not win last time goes.
  always_comb begin
    w_alu_grant = alu_valid && (!mem_valid || (r_last_grant == WB_MEM));
    w_mem_grant = mem_valid && !w_alu_grant;
  end

  // Reset to MEM so the ALU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= WB_MEM;
    end else if (w_alu_grant) begin
      r_last_grant <= WB_ALU;
    end else if (w_mem_grant) begin
      r_last_grant <= WB_MEM;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  assign alu_ready = w_alu_grant;
  assign mem_ready = w_mem_grant;

  // Payload of the granted source.
  always_comb begin
    if (w_alu_grant) begin
      w_win_add  = alu_add;
      w_win_data = alu_data;
    end else begin
      w_win_add  = mem_add;
      w_win_data = mem_data;
    end
  end

  // Write port: address and data hold when nothing is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_wadd  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_alu_grant || w_mem_grant;
      if (w_alu_grant || w_mem_grant) begin
        r_wadd  <= w_win_add;
        r_wdata <= w_win_data;
      end else begin
        r_wadd  <= r_wadd;
        r_wdata <= r_wdata;
      end
    end
  end

  assign write_enable = r_we;
  assign write_add    = {{(RF_ADD_W-ADDR_W){1'b0}}, r_wadd};
  assign z5_output    = r_wdata;

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_add   (issue_add),
    .issue_ready (issue_ready),
    .clr_en      (r_we),
    .clr_add     (r_wadd),
    .r1_add      (r1_add),
    .r2_add      (r2_add),
    .hazard      (hazard),
    .busy        (busy)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a behavioural model of the grant and scoreboard rules.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic        alu_ready, mem_ready, issue_ready, hazard, write_enable;
  logic [4:0]  alu_add, mem_add, issue_add, r1_add, r2_add;
  logic [31:0] alu_data, mem_data, busy, write_add, z5_output;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_add      (alu_add),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_add      (mem_add),
    .mem_data     (mem_data),
    .issue_valid  (issue_valid),
    .issue_add    (issue_add),
    .issue_ready  (issue_ready),
    .r1_add       (r1_add),
    .r2_add       (r2_add),
    .hazard       (hazard),
    .busy         (busy),
    .write_enable (write_enable),
    .write_add    (write_add),
    .z5_output    (z5_output)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    alu_add = 5'd0; mem_add = 5'd0; issue_add = 5'd0;
    r1_add = 5'd0; r2_add = 5'd0;
    alu_data = 32'd0; mem_data = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    checks++;
    if ({write_enable, write_add, z5_output, busy} !== 97'd0) begin
      errors++;
      $display("FAIL reset_state: we=%0b add=%0h data=%0h busy=%0h, want all 0",
               write_enable, write_add, z5_output, busy);
    end
    apply_reset();
  endtask

  task automatic test_single_alu();
    apply_reset();
    alu_valid = 1'b1; alu_add = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: alu_ready=%0b mem_ready=%0b we=%0b, want 1 0 0",
               alu_ready, mem_ready, write_enable);
    end
    next_cycle();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b1 || write_add !== 32'd3 || z5_output !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: we=%0b add=%0h data=%0h, want 1 3 deadbeef",
               write_enable, write_add, z5_output);
    end
    next_cycle();
    checks++;
    if (write_enable !== 1'b0 || write_add !== 32'd3 || z5_output !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_hold: we=%0b add=%0h data=%0h, want 0 3 deadbeef",
               write_enable, write_add, z5_output);
    end
  endtask

  task automatic test_tie();
    logic [4:0] exp_add [4];
`ifdef RF_MEM_PRIORITY_EN
    exp_add = '{5'd2, 5'd2, 5'd2, 5'd2};
`else
    exp_add = '{5'd1, 5'd2, 5'd1, 5'd2};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      alu_valid = (i < 4); alu_add = 5'd1; alu_data = 32'h100 + i;
      mem_valid = (i < 4); mem_add = 5'd2; mem_data = 32'h200 + i;
      #1;
      if (i < 4) begin
        checks++;
        if (alu_ready !== (exp_add[i] == 5'd1) || mem_ready !== (exp_add[i] == 5'd2)) begin
          errors++;
          $display("FAIL tie_grant[%0d]: alu_ready=%0b mem_ready=%0b, want grant to reg %0d",
                   i, alu_ready, mem_ready, exp_add[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if (write_enable !== 1'b1 || write_add !== {27'd0, exp_add[i-1]}) begin
          errors++;
          $display("FAIL tie_write[%0d]: we=%0b add=%0d, want 1 %0d",
                   i - 1, write_enable, write_add, exp_add[i-1]);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    issue_valid = 1'b1; issue_add = 5'd7;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue_first: issue_ready=%0b, want 1", issue_ready);
    end
    next_cycle();
    r1_add = 5'd7; r2_add = 5'd0;
    #1;
    checks++;
    if (busy[7] !== 1'b1 || issue_ready !== 1'b0 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy: busy7=%0b issue_ready=%0b hazard=%0b, want 1 0 1",
               busy[7], issue_ready, hazard);
    end
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_add = 5'd7; mem_data = 32'h0000_7777;
    next_cycle();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b1 || busy[7] !== 1'b1 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL sb_commit_cycle: we=%0b busy7=%0b hazard=%0b, want 1 1 1",
               write_enable, busy[7], hazard);
    end
    next_cycle();
    checks++;
    if (busy[7] !== 1'b0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: busy7=%0b hazard=%0b, want 0 0", busy[7], hazard);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    issue_valid = 1'b1; issue_add = 5'd9;
    next_cycle();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_add = 5'd9; alu_data = 32'h99;
    next_cycle();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_add = 5'd4;
    #1;
    checks++;
    if (write_enable !== 1'b1 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_setup: we=%0b issue_ready=%0b, want 1 1",
               write_enable, issue_ready);
    end
    next_cycle();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 32'h0000_0010) begin
      errors++;
      $display("FAIL same_cycle_busy: busy=%08h, want 00000010", busy);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 4; k < 8; k++) begin
      issue_valid = 1'b1; issue_add = k[4:0];
      next_cycle();
    end
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_add = 5'd1; alu_data = 32'h5;
    next_cycle();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 32'h0000_00F0 || write_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: busy=%08h we=%0b, want 000000f0 1", busy, write_enable);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 32'd0 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%08h we=%0b, want 0 0", busy, write_enable);
    end
    #2;
    reset = 1'b1;
    next_cycle();
    alu_valid = 1'b1; alu_add = 5'd1;
    mem_valid = 1'b1; mem_add = 5'd2;
    #1;
    checks++;
`ifdef RF_MEM_PRIORITY_EN
    if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
`else
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
`endif
      errors++;
      $display("FAIL mid_first_tie: alu_ready=%0b mem_ready=%0b", alu_ready, mem_ready);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_nonbusy_write();
    apply_reset();
    mem_valid = 1'b1; mem_add = 5'd12; mem_data = 32'hC0FFEE12;
    next_cycle();
    mem_valid = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b1 || write_add !== 32'd12 || busy !== 32'd0) begin
      errors++;
      $display("FAIL nonbusy_write: we=%0b add=%0d busy=%08h, want 1 12 0",
               write_enable, write_add, busy);
    end
    next_cycle();
    checks++;
    if (write_enable !== 1'b0 || busy !== 32'd0) begin
      errors++;
      $display("FAIL nonbusy_after: we=%0b busy=%08h, want 0 0", write_enable, busy);
    end
  endtask

  // Model: a set of busy registers, the last winner, and the pending write.
  task automatic test_random();
    bit          busy_set [32];
    bit          last_was_mem;
    bit          m_we;
    logic [4:0]  m_add;
    logic [31:0] m_data;
    bit          a_pend, l_pend;
    logic [4:0]  a_add, l_add;
    logic [31:0] a_data, l_data;
    bit          e_alu, e_mem, e_ir, e_hz;
    logic [31:0] e_busy;
    apply_reset();
    foreach (busy_set[j]) busy_set[j] = 1'b0;
    last_was_mem = 1'b1; m_we = 1'b0; m_add = 5'd0; m_data = 32'd0;
    a_pend = 1'b0; l_pend = 1'b0; a_add = 5'd0; l_add = 5'd0;
    a_data = 32'd0; l_data = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend = 1'b1; a_add = 5'($urandom); a_data = $urandom;
      end
      if (!l_pend && $urandom_range(0, 2) == 0) begin
        l_pend = 1'b1; l_add = 5'($urandom); l_data = $urandom;
      end
      alu_valid = a_pend; alu_add = a_add; alu_data = a_data;
      mem_valid = l_pend; mem_add = l_add; mem_data = l_data;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_add = 5'($urandom);
      r1_add = 5'($urandom);
      r2_add = 5'($urandom);
      #1;
`ifdef RF_MEM_PRIORITY_EN
      e_alu = a_pend && !l_pend;
`else
      e_alu = a_pend && (!l_pend || last_was_mem);
`endif
      e_mem = l_pend && !e_alu;
      e_ir = !busy_set[issue_add];
      e_hz = busy_set[r1_add] || busy_set[r2_add] ||
             (m_we && (m_add == r1_add || m_add == r2_add));
      e_busy = 32'd0;
      for (int j = 0; j < 32; j++) e_busy[j] = busy_set[j];
      checks++;
      if ({alu_ready, mem_ready, issue_ready, hazard, write_enable} !==
          {e_alu, e_mem, e_ir, e_hz, m_we}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got ar/mr/ir/hz/we=%05b, want %05b", c,
                 {alu_ready, mem_ready, issue_ready, hazard, write_enable},
                 {e_alu, e_mem, e_ir, e_hz, m_we});
      end
      checks++;
      if (busy !== e_busy || write_add !== {27'd0, m_add} || z5_output !== m_data) begin
        errors++;
        $display("FAIL rand_state[%0d]: busy=%08h add=%0d data=%08h, want %08h %0d %08h",
                 c, busy, write_add, z5_output, e_busy, m_add, m_data);
      end
      if (issue_valid && e_ir) busy_set[issue_add] = 1'b1;
      if (m_we) busy_set[m_add] = 1'b0;
      m_we = e_alu || e_mem;
      if (e_alu) begin
        m_add = a_add; m_data = a_data; a_pend = 1'b0; last_was_mem = 1'b0;
      end else if (e_mem) begin
        m_add = l_add; m_data = l_data; l_pend = 1'b0; last_was_mem = 1'b1;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_alu();
    test_tie();
    test_scoreboard();
    test_same_cycle();
    test_reset_mid();
    test_nonbusy_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
